booth_accumulator: RTL and testbench

Sequential signed accumulator placed directly downstream of the combinational 4-bit `booth` multiplier. It takes the 8-bit signed product `mul` through a valid/ready handshake and sums a fixed number of products, `N`, per result. It then presents the sum on a held output handshake, so the multiplier datapath becomes a multiply-accumulate (dot-product) unit. The accumulator detects signed overflow and, optionally, saturates.

---
 rtl/booth_accumulator.sv | 98 +++++++++
 tb/tb_booth_accumulator.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_accumulator.sv
// Signed multiply-accumulate back end: sums N products from the booth multiplier per result.
// Optional macro BOOTH_ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module booth_accumulator #(
    parameter int ACC_W = 12,
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {ST_ACC, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               ovf_reg, ovf_next;

    logic [ACC_W:0]     sum;
    logic               sum_ovf;
    logic [ACC_W-1:0]   add_result;

    // One guard bit above the accumulator; a sign mismatch in the top two bits means overflow.
    assign sum     = {acc_reg[ACC_W-1], acc_reg} + {{(ACC_W-7){prod[7]}}, prod};
    assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef BOOTH_ACC_SAT_EN
    // The guard bit carries the sign of the true result, so it selects the clamp direction.
    always_comb begin
        add_result = sum[ACC_W-1:0];
        if (sum_ovf) begin
            add_result = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign add_result = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACC;
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        prod_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_ACC: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    acc_next   = add_result;
                    count_next = count_reg + CNT_W'(1);
                    ovf_next   = ovf_reg | sum_ovf;
                    if (count_reg == CNT_W'(N - 1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    assign out_acc = acc_reg;
    assign ovf     = ovf_reg;
    assign count   = count_reg;

endmodule

// File: tb/tb_booth_accumulator.sv
// Bench for booth_accumulator: directed scenarios plus randomized traffic against an
// integer reference model, on three configurations (12b/N=4, 8b/N=4, 8b/N=1).
module tb_booth_accumulator;

`ifdef BOOTH_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [7:0] OVF_EXP = SAT ? 8'h7F : 8'h80;

    logic       clk;
    logic       rst;
    logic [7:0] prod;
    logic       prod_valid;
    logic       out_ready;

    logic        a_prod_ready, a_out_valid, a_ovf;
    logic [11:0] a_out_acc;
    logic [2:0]  a_count;
    logic        b_prod_ready, b_out_valid, b_ovf;
    logic [7:0]  b_out_acc;
    logic [2:0]  b_count;
    logic        c_prod_ready, c_out_valid, c_ovf;
    logic [7:0]  c_out_acc;
    logic [0:0]  c_count;

    int checks = 0;
    int errors = 0;

    booth_accumulator #(.ACC_W(12), .N(4)) dut_a (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(a_prod_ready),
        .out_acc(a_out_acc), .out_valid(a_out_valid), .out_ready(out_ready), .ovf(a_ovf),
        .count(a_count));

    booth_accumulator #(.ACC_W(8), .N(4)) dut_b (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(b_prod_ready),
        .out_acc(b_out_acc), .out_valid(b_out_valid), .out_ready(out_ready), .ovf(b_ovf),
        .count(b_count));

    booth_accumulator #(.ACC_W(8), .N(1)) dut_c (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(c_prod_ready),
        .out_acc(c_out_acc), .out_valid(c_out_valid), .out_ready(out_ready), .ovf(c_ovf),
        .count(c_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: true integer sum, then wrap or clamp into the signed W-bit range.
    typedef struct packed {
        int acc;
        int cnt;
        bit ovf;
        bit done;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t step(mdl_t m, int w, int n, logic r, logic pv,
                                  logic [7:0] p, logic ordy);
        mdl_t x = m;
        int t;
        int lim;
        lim = 1 << (w - 1);
        if (r) begin
            x = '0;
        end else if (m.done) begin
            if (ordy) x = '0;
        end else if (pv) begin
            t = m.acc + int'($signed(p));
            if (t >= lim || t < -lim) begin
                x.ovf = 1'b1;
                if (SAT) t = (t >= lim) ? lim - 1 : -lim;
                else     t = (t >= lim) ? t - 2 * lim : t + 2 * lim;
            end
            x.acc = t;
            x.cnt = m.cnt + 1;
            if (x.cnt == n) x.done = 1'b1;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, 12, 4, rst, prod_valid, prod, out_ready);
        mb <= step(mb, 8, 4, rst, prod_valid, prod, out_ready);
        mc <= step(mc, 8, 1, rst, prod_valid, prod, out_ready);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input int v);
        prod       = 8'(v);
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; prod_valid = 1'b1; prod = 8'h31; out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b prod_ready=%b, required 0 1",
                     a_out_valid, a_prod_ready);
        end
        checks++;
        if (a_out_acc !== 12'd0 || a_ovf !== 1'b0 || a_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: out_acc=%h ovf=%b count=%0d, required 000 0 0",
                     a_out_acc, a_ovf, a_count);
        end
        rst = 1'b0; prod_valid = 1'b0;
        tick();
        $display("reset: out_acc=%h count=%0d", a_out_acc, a_count);
    endtask

    task automatic test_basic();
        feed(-49); feed(49); feed(42);
        checks++;
        if (a_out_valid !== 1'b0 || a_count !== 3'd3) begin
            errors++;
            $display("FAIL basic_partial: out_valid=%b count=%0d, required 0 3",
                     a_out_valid, a_count);
        end
        feed(-8);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_acc !== 12'h022 || a_ovf !== 1'b0 ||
            a_count !== 3'd4 || a_prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: valid=%b acc=%h ovf=%b count=%0d ready=%b, required 1 022 0 4 0",
                     a_out_valid, a_out_acc, a_ovf, a_count, a_prod_ready);
        end
        checks++;
        if (c_out_valid !== 1'b1 || c_out_acc !== 8'hCF || c_count !== 1'b1) begin
            errors++;
            $display("FAIL n1_hold: valid=%b acc=%h count=%0d, required 1 cf 1",
                     c_out_valid, c_out_acc, c_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (a_prod_ready !== 1'b1 || a_count !== 3'd0 || a_out_acc !== 12'd0) begin
            errors++;
            $display("FAIL basic_release: ready=%b count=%0d acc=%h, required 1 0 000",
                     a_prod_ready, a_count, a_out_acc);
        end
        $display("basic: result 34 released");
    endtask

    task automatic test_gaps_backpressure();
        int vals[4] = '{-49, 49, 42, -8};
        foreach (vals[i]) begin
            feed(vals[i]);
            tick();
            tick();
        end
        prod = 8'h10; prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_out_acc !== 12'h022 || a_prod_ready !== 1'b0 || a_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: acc=%h ready=%b valid=%b, required 022 0 1",
                         i, a_out_acc, a_prod_ready, a_out_valid);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (a_prod_ready !== 1'b1 || a_out_acc !== 12'd0 || a_count !== 3'd0) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b acc=%h count=%0d, required 1 000 0",
                     a_prod_ready, a_out_acc, a_count);
        end
        tick();
        prod_valid = 1'b0;
        checks++;
        if (a_count !== 3'd1 || a_out_acc !== 12'h010) begin
            errors++;
            $display("FAIL pending_accept: count=%0d acc=%h, required 1 010",
                     a_count, a_out_acc);
        end
        $display("gaps_backpressure: pending product taken as first of next result");
    endtask

    task automatic test_overflow();
        pulse_reset();
        feed(64); feed(64); feed(0); feed(0);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_acc !== OVF_EXP || b_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_8b: valid=%b acc=%h ovf=%b, required 1 %h 1",
                     b_out_valid, b_out_acc, b_ovf, OVF_EXP);
        end
        checks++;
        if (a_out_acc !== 12'd128 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_12b: acc=%h ovf=%b, required 080 0", a_out_acc, a_ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (b_ovf !== 1'b0 || b_out_valid !== 1'b0 || b_out_acc !== 8'd0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b valid=%b acc=%h, required 0 0 00",
                     b_ovf, b_out_valid, b_out_acc);
        end
        $display("overflow: 64+64+0+0 -> %h", OVF_EXP);
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        feed(20); feed(30);
        checks++;
        if (a_count !== 3'd2 || a_out_acc !== 12'd50) begin
            errors++;
            $display("FAIL mid_partial: count=%0d acc=%h, required 2 032", a_count, a_out_acc);
        end
        pulse_reset();
        checks++;
        if (a_count !== 3'd0 || a_out_acc !== 12'd0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d acc=%h, required 0 000", a_count, a_out_acc);
        end
        feed(1); feed(2); feed(3); feed(4);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_acc !== 12'd10 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_result: valid=%b acc=%h ovf=%b, required 1 00a 0",
                     a_out_valid, a_out_acc, a_ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("reset_mid: result 10");
    endtask

    task automatic test_end_to_end();
        int a = -7;
        pulse_reset();
        for (int b = -7; b <= -4; b++) feed(a * b);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_acc !== 12'd154 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL end_to_end: valid=%b acc=%0d ovf=%b, required 1 154 0",
                     a_out_valid, a_out_acc, a_ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("end_to_end: A=-7 sweep -> %0d", a_out_acc);
    endtask

    task automatic test_random();
        logic [17:0] a_exp;
        logic [13:0] b_exp;
        logic [11:0] c_exp;
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            prod_valid = ($urandom_range(0, 3) != 0);
            prod       = 8'($urandom);
            out_ready  = ($urandom_range(0, 2) == 0);
            tick();
            a_exp = {ma.done, ~ma.done, ma.ovf, 3'(ma.cnt), 12'(ma.acc)};
            b_exp = {mb.done, ~mb.done, mb.ovf, 3'(mb.cnt), 8'(mb.acc)};
            c_exp = {mc.done, ~mc.done, mc.ovf, 1'(mc.cnt), 8'(mc.acc)};
            checks++;
            if ({a_out_valid, a_prod_ready, a_ovf, a_count, a_out_acc} !== a_exp) begin
                errors++;
                $display("FAIL random_a[%0d]: got %h, required %h", i,
                         {a_out_valid, a_prod_ready, a_ovf, a_count, a_out_acc}, a_exp);
            end
            checks++;
            if ({b_out_valid, b_prod_ready, b_ovf, b_count, b_out_acc} !== b_exp) begin
                errors++;
                $display("FAIL random_b[%0d]: got %h, required %h", i,
                         {b_out_valid, b_prod_ready, b_ovf, b_count, b_out_acc}, b_exp);
            end
            checks++;
            if ({c_out_valid, c_prod_ready, c_ovf, c_count, c_out_acc} !== c_exp) begin
                errors++;
                $display("FAIL random_c[%0d]: got %h, required %h", i,
                         {c_out_valid, c_prod_ready, c_ovf, c_count, c_out_acc}, c_exp);
            end
        end
        rst = 1'b0; prod_valid = 1'b0; out_ready = 1'b0;
        $display("random: 600 cycles compared on three configurations");
    endtask

    initial begin
        rst = 1'b1; prod_valid = 1'b0; prod = 8'h00; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps_backpressure();
        test_overflow();
        test_reset_mid();
        test_end_to_end();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
